// File: rtl/switch_debounce.sv
// Debounced slide-switch reader: per-channel sync + bounce filter, edge pulses,
// a single-entry event buffer and the registered f1 LED output.

module switch_debounce_ch #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_d_o,
  output logic rise_d_o,
  output logic fall_d_o,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  typedef enum logic [1:0] {STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO} st_e;

  st_e              st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, s_q;
  logic             level_q, rise_q, fall_q;
  logic             rise_d, fall_d, level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      st_q    <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      s_q     <= sync1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // cnt counts consecutive samples that disagree with the accepted level;
  // acceptance happens on the DB_CYCLES-th, so cnt never exceeds DB_CYCLES-1.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    case (st_q)
      STABLE_LO: if (s_q) begin
        st_d  = CHECK_HI;
        cnt_d = CNT_W'(1);
      end
      CHECK_HI: if (!s_q) begin
        st_d  = STABLE_LO;
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        st_d   = STABLE_HI;
        cnt_d  = '0;
        rise_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      STABLE_HI: if (!s_q) begin
        st_d  = CHECK_LO;
        cnt_d = CNT_W'(1);
      end
      CHECK_LO: if (s_q) begin
        st_d  = STABLE_HI;
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        st_d   = STABLE_LO;
        cnt_d  = '0;
        fall_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        st_d  = STABLE_LO;
        cnt_d = '0;
      end
    endcase
    level_d = (st_d == STABLE_HI) || (st_d == CHECK_LO);
  end

  assign level_d_o = level_d;
  assign rise_d_o  = rise_d;
  assign fall_d_o  = fall_d;
  assign level_o   = level_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
endmodule

module switch_debounce #(
  parameter int N_CH      = 2,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         sw_raw,
  output logic [N_CH-1:0]         sw_level,
  output logic [N_CH-1:0]         sw_rise,
  output logic [N_CH-1:0]         sw_fall,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  output logic                    evt_dir,
  output logic                    evt_ovf,
  output logic                    f1_led
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0] lvl_d, rise_d, fall_d, pulse;
  logic            any_p, multi, found, load;
  logic [CH_W-1:0] win_ch;
  logic            win_dir;
  logic            vld_q, vld_d, dir_q, dir_d, ovf_q, ovf_d, f1_q, f1_d;
  logic [CH_W-1:0] ch_q, ch_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    switch_debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_i     (sw_raw[i]),
      .level_d_o (lvl_d[i]),
      .rise_d_o  (rise_d[i]),
      .fall_d_o  (fall_d[i]),
      .level_o   (sw_level[i]),
      .rise_o    (sw_rise[i]),
      .fall_o    (sw_fall[i])
    );
  end

  // The buffer works off next-state pulses so the event lands on the same
  // edge as the level change; lowest channel wins, the rest count as dropped.
  always_comb begin
    pulse   = rise_d | fall_d;
    any_p   = |pulse;
    multi   = |(pulse & (pulse - N_CH'(1)));
    found   = 1'b0;
    win_ch  = '0;
    win_dir = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (pulse[i] && !found) begin
        found   = 1'b1;
        win_ch  = CH_W'(i);
        win_dir = rise_d[i];
      end
    end
    load  = any_p && (!vld_q || evt_ready);
    vld_d = load ? 1'b1 : (vld_q && !evt_ready);
    ch_d  = load ? win_ch : ch_q;
    dir_d = load ? win_dir : dir_q;
    ovf_d = ovf_q | (any_p && (!load || multi));
    f1_d  = lvl_d[0] | (lvl_d[0] & ~lvl_d[1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      ch_q  <= '0;
      dir_q <= 1'b0;
      ovf_q <= 1'b0;
      f1_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      ch_q  <= ch_d;
      dir_q <= dir_d;
      ovf_q <= ovf_d;
      f1_q  <= f1_d;
    end
  end

  assign evt_valid = vld_q;
  assign evt_ch    = ch_q;
  assign evt_dir   = dir_q;
  assign evt_ovf   = ovf_q;
  assign f1_led    = f1_q;
endmodule
